// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall/flush steering, IF/ID register, stall counter.
// IF/ID and stallCount are registered (one-cycle latency); imemReady=0 holds the PC and inserts a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcWrite,
    input  logic             ifIdFlush,
    input  logic             branchTaken,
    input  logic [31:0]      branchTarget,
    output logic [31:0]      imemAddr,
    input  logic [31:0]      imemData,
    input  logic             imemReady,
    output logic [31:0]      instrID,
    output logic [31:0]      pc4ID,
    output logic             validID,
    output logic [CNT_W-1:0] stallCount
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        stall_d = stall_q;

        // A redirect wins over a stall so the resolved branch is never dropped.
        if (branchTaken) begin
            pc_d = branchTarget & 32'hFFFF_FFFC;
        end else if (pcWrite && imemReady) begin
            pc_d = pc_plus4;
        end

        if (ifIdFlush || branchTaken) begin
            instr_d = 32'h00000000;
            pc4_d   = 32'h00000000;
            valid_d = 1'b0;
        end else if (pcWrite) begin
            if (imemReady) begin
                instr_d = imemData;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end else begin
                instr_d = 32'h00000000;
                pc4_d   = 32'h00000000;
                valid_d = 1'b0;
            end
        end

        if (!pcWrite && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            instr_q <= 32'h00000000;
            pc4_q   <= 32'h00000000;
            valid_q <= 1'b0;
            stall_q <= {CNT_W{1'b0}};
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    assign imemAddr   = pc_q;
    assign instrID    = instr_q;
    assign pc4ID      = pc4_q;
    assign validID    = valid_q;
    assign stallCount = stall_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected post-edge state, a monitor pops and compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcWrite, ifIdFlush, branchTaken, imemReady;
    logic [31:0] branchTarget, imemAddr, imemData, instrID, pc4ID;
    logic        validID;
    logic [3:0]  stallCount;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [3:0]  stall;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEE0;
    endfunction

    assign imemData = mem(imemAddr);

    fetch_stage #(.RESET_PC(32'h00000000), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pcWrite     (pcWrite),
        .ifIdFlush   (ifIdFlush),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .imemReady   (imemReady),
        .instrID     (instrID),
        .pc4ID       (pc4ID),
        .validID     (validID),
        .stallCount  (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    // Monitor: the DUT presents a new fetch state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".pc"},    imemAddr,            e.pc);
                chk({e.name, ".instr"}, instrID,             e.instr);
                chk({e.name, ".pc4"},   pc4ID,               e.pc4);
                chk({e.name, ".valid"}, {31'd0, validID},    {31'd0, e.valid});
                chk({e.name, ".stall"}, {28'd0, stallCount}, {28'd0, e.stall});
            end
        end
    end

    task automatic step(input logic pw, input logic fl, input logic br, input logic [31:0] tgt,
                        input logic rdy, input logic [31:0] epc, input logic [31:0] ei,
                        input logic [31:0] ep4, input logic ev, input logic [3:0] es,
                        input string nm);
        exp_t e;
        @(negedge clk);
        pcWrite = pw; ifIdFlush = fl; branchTaken = br; branchTarget = tgt; imemReady = rdy;
        e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.stall = es; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".pc"},    imemAddr,            32'h0);
        chk({nm, ".instr"}, instrID,             32'h0);
        chk({nm, ".pc4"},   pc4ID,               32'h0);
        chk({nm, ".valid"}, {31'd0, validID},    32'h0);
        chk({nm, ".stall"}, {28'd0, stallCount}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; pcWrite = 1'b1; ifIdFlush = 1'b0; branchTaken = 1'b0;
        branchTarget = 32'h0; imemReady = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_state("reset");
        reset = 1'b0;

        // Sequential fetch from reset PC
        step(1, 0, 0, 0, 1, 32'h04, mem(32'h00), 32'h04, 1, 0, "seq0");
        step(1, 0, 0, 0, 1, 32'h08, mem(32'h04), 32'h08, 1, 0, "seq1");
        step(1, 0, 0, 0, 1, 32'h0C, mem(32'h08), 32'h0C, 1, 0, "seq2");
        step(1, 0, 0, 0, 1, 32'h10, mem(32'h0C), 32'h10, 1, 0, "seq3");
        // Two-cycle stall at 0x10 holds PC and IF/ID
        step(0, 0, 0, 0, 1, 32'h10, mem(32'h0C), 32'h10, 1, 1, "stall0");
        step(0, 0, 0, 0, 1, 32'h10, mem(32'h0C), 32'h10, 1, 2, "stall1");
        step(1, 0, 0, 0, 1, 32'h14, mem(32'h10), 32'h14, 1, 2, "resume");
        step(1, 0, 0, 0, 1, 32'h18, mem(32'h14), 32'h18, 1, 2, "seq4");
        step(1, 0, 0, 0, 1, 32'h1C, mem(32'h18), 32'h1C, 1, 2, "seq5");
        step(1, 0, 0, 0, 1, 32'h20, mem(32'h1C), 32'h20, 1, 2, "seq6");
        // Flush with stall at 0x20
        step(0, 1, 0, 0, 1, 32'h20, 32'h0, 32'h0, 0, 3, "flush");
        step(1, 0, 0, 0, 1, 32'h24, mem(32'h20), 32'h24, 1, 3, "post_flush");
        // Branch overrides stall; low target bits cleared
        step(0, 0, 1, 32'h103, 1, 32'h100, 32'h0, 32'h0, 0, 4, "br_stall");
        step(1, 0, 0, 0, 1, 32'h104, mem(32'h100), 32'h104, 1, 4, "br_tgt");
        // imemReady low for 3 cycles at 0x40
        step(1, 0, 1, 32'h40, 1, 32'h40, 32'h0, 32'h0, 0, 4, "br40");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 4, $sformatf("notrdy%0d", i));
        step(1, 0, 0, 0, 1, 32'h44, mem(32'h40), 32'h44, 1, 4, "rdy40");
        // PC wrap at the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 4, "br_top");
        step(1, 0, 0, 0, 1, 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1, 4, "wrap");
        // Stall counter saturates at 15 and stays there
        for (int i = 0; i < 13; i++)
            step(0, 0, 0, 0, 1, 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1,
                 ((5 + i) > 15) ? 4'd15 : 4'(5 + i), $sformatf("sat%0d", i));

        // Drain scoreboard with a bound
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left expected 0", sb.size());

        // Async reset mid-cycle with a redirect pending
        @(negedge clk);
        pcWrite = 1'b0; branchTaken = 1'b1; branchTarget = 32'h200;
        #2 reset = 1'b1;
        #1 chk_reset_state("async_rst");
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1, 0, 0, 0, 1, 32'h04, mem(32'h00), 32'h04, 1, 0, "after_rst");
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain2: %0d entries left expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
